cell_pick_engine: RTL
=====================

# cell_pick_engine

Parametrised mouse-to-board-cell locator for the game datapath, between the mouse/click inputs and the mine-board logic. On a button press inside the board it computes the 1-based cell column/row with a sequential restoring divider (one quotient bit per clock on both axes). It then presents a typed click event on a valid/ready handshake. Replaces the combinational per-cycle division with a fixed-latency pipelined event with backpressure.

## Interface
- POS_W, 12: width of mouse, board-position, board-size and button-size operands.
- IDX_W, 5: width of cell index outputs.
- MAX_CELLS, 16: largest legal cells-per-side; index clamp ceiling.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- mouse_xpos, mouse_ypos  in  POS_W  pointer position, pixels.
- left, right  in  1  mouse button levels, synchronous to clk.
- board_xpos, board_ypos  in  POS_W  board top-left corner.
- board_size  in  POS_W  board side length, pixels.
- button_size  in  POS_W  cell side length, pixels.
- board_cells  in  IDX_W  cells per side in current level, 1..MAX_CELLS.
- evt_valid  out  1  click event available.
- evt_ready  in  1  consumer accepts event.
- evt_x, evt_y  out  IDX_W  1-based cell column/row.
- evt_type  out  2  01 dig (left), 10 flag (right), 11 chord, 00 never while valid.
- busy  out  1  high in CALC or OUT.
- miss  out  1  one-cycle pulse when a press edge is rejected.

## Operation
- Edge detect: registered copies left_q/right_q; press = level high and copy low. Copies reset to 1, so a button held through reset release gives no event.
- Inside test, (POS_W+1)-bit arithmetic, inclusive: mouse_x in [board_xpos, board_xpos+board_size], same for y.
- Offsets: ox = mouse_x-board_xpos, oy = mouse_y-board_ypos, captured with inputs at the accepting edge. board_* and button_size are sampled once, with the press; later changes do not affect the running event.
- FSM states IDLE, CALC, OUT:
  - IDLE: a press edge that is inside and has button_size != 0 captures offsets, divisor and type, loads bit counter with POS_W-1, and moves to CALC. Any other press edge pulses miss.
  - CALC: one restoring-division step per cycle on x and y in parallel. After the counter-0 step, moves to OUT.
  - OUT: evt_valid=1; outputs are held stable. Stays until evt_valid&&evt_ready, then moves to IDLE.
- Result: idx = quotient+1, saturated to board_cells. Example: offset == board_size at the exact right edge maps to the last cell. If board_cells > MAX_CELLS, clamp to MAX_CELLS.
- Type without chord feature: left priority. Simultaneous left+right edges give 01.
- Press edges seen in CALC or OUT are dropped and pulse miss. They are not queued.
- Levels with no edge (button held) never generate events.

## Timing
- Reset values: evt_valid=0, evt_x=0, evt_y=0, evt_type=00, busy=0, miss=0, state IDLE, counter 0.
- Rising edge k samples the press → CALC from edge k. evt_valid rises after edge k+POS_W (e.g. 12 cycles later for POS_W=12).
- Handshake: transfer on the edge where valid&&ready. Valid drops the next cycle. Earliest next accept is the edge after return to IDLE, giving a throughput of one event per POS_W+2 cycles.
- ready held high before valid is legal. The event still spends at least one cycle in OUT.
- miss is registered: it pulses in the cycle after the rejecting edge.
- Asserting rst_n low mid-CALC or mid-OUT clears state immediately, with no event emitted. Outputs return to reset values asynchronously.

## Configuration
- CELL_PICK_CHORD_EN defined: left and right press edges in the same cycle yield evt_type=11. A right edge while left is already held also yields 11, and likewise a left edge while right is held.
- Undefined: chord never produced. Left priority as above; held-other-button ignored.

## Test plan
- Parameters POS_W=12, board_xpos=100, board_ypos=50, board_size=320, button_size=20, board_cells=16 throughout.
- Left edge at (145,95), ready=1 → after 12 cycles one valid beat: x=3, y=3, type=01; busy high 13 cycles.
- Right edge at (420,370) → offsets 320/20=16, +1=17 clamped → x=16, y=16, type=10.
- Left edge at (99,95) → miss pulse; no valid, busy stays 0. Repeat with button_size=0 at (145,95) → miss.
- Backpressure: ready low 5 cycles after valid → outputs stable all 5. A left edge during OUT → miss. ready=1 → one transfer, return to IDLE.
- Simultaneous left+right edge at (300,200) → type=01 without CELL_PICK_CHORD_EN, 11 with it; x=11, y=8.
- rst_n low on the 4th CALC cycle → all outputs 0 at once. Left held through release → no event until release and re-press.

Source files
------------

// File: rtl/cell_pick_engine.sv
// Maps a mouse press inside the board to a 1-based cell column/row using a restoring divider.
// The event is valid POS_W cycles after the press; optional chord detection when CELL_PICK_CHORD_EN is defined.
module cell_pick_engine #(
    parameter int POS_W     = 12,
    parameter int IDX_W     = 5,
    parameter int MAX_CELLS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [POS_W-1:0] mouse_xpos,
    input  logic [POS_W-1:0] mouse_ypos,
    input  logic             left,
    input  logic             right,
    input  logic [POS_W-1:0] board_xpos,
    input  logic [POS_W-1:0] board_ypos,
    input  logic [POS_W-1:0] board_size,
    input  logic [POS_W-1:0] button_size,
    input  logic [IDX_W-1:0] board_cells,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_x,
    output logic [IDX_W-1:0] evt_y,
    output logic [1:0]       evt_type,
    output logic             busy,
    output logic             miss
);
    localparam int CW = (POS_W > 1) ? $clog2(POS_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

    state_t             r_state, w_state_nx;
    logic               r_left_q, r_right_q;
    logic [POS_W-1:0]   r_dx, r_dy, r_rx, r_ry, r_qx, r_qy, r_div;
    logic [IDX_W-1:0]   r_cap, r_evt_x, r_evt_y;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_type;
    logic               r_miss;

    logic               w_lp, w_rp, w_press, w_inside, w_accept;
    logic [POS_W:0]     w_xend, w_yend, w_sx, w_sy;
    logic [POS_W-1:0]   w_ox, w_oy, w_qx_fin, w_qy_fin;
    logic [IDX_W-1:0]   w_cap;
    logic [1:0]         w_type;

    // One restoring step: returns {quotient bit, new remainder}.
    function automatic logic [POS_W:0] div_step(input logic [POS_W-1:0] rem,
                                                 input logic msb,
                                                 input logic [POS_W-1:0] dv);
        logic [POS_W:0] sh;
        sh = {rem, msb};
        if (sh >= {1'b0, dv}) begin
            sh = sh - {1'b0, dv};
            return {1'b1, sh[POS_W-1:0]};
        end
        return {1'b0, sh[POS_W-1:0]};
    endfunction

    function automatic logic [IDX_W-1:0] sat_idx(input logic [POS_W-1:0] q,
                                                 input logic [IDX_W-1:0] cap);
        logic [POS_W:0] s;
        s = {1'b0, q} + (POS_W+1)'(1);
        if (s > (POS_W+1)'(cap))
            return cap;
        return s[IDX_W-1:0];
    endfunction

    assign w_lp    = left  & ~r_left_q;
    assign w_rp    = right & ~r_right_q;
    assign w_press = w_lp | w_rp;

    assign w_xend   = {1'b0, board_xpos} + {1'b0, board_size};
    assign w_yend   = {1'b0, board_ypos} + {1'b0, board_size};
    assign w_inside = (mouse_xpos >= board_xpos) && ({1'b0, mouse_xpos} <= w_xend) &&
                      (mouse_ypos >= board_ypos) && ({1'b0, mouse_ypos} <= w_yend);
    assign w_accept = (r_state == S_IDLE) && w_press && w_inside && (button_size != '0);

    assign w_ox  = mouse_xpos - board_xpos;
    assign w_oy  = mouse_ypos - board_ypos;
    assign w_cap = (board_cells > IDX_W'(MAX_CELLS)) ? IDX_W'(MAX_CELLS) : board_cells;

`ifdef CELL_PICK_CHORD_EN
    // A new edge on one button while the other is down (or edging) is a chord.
    assign w_type = ((w_lp && right) || (w_rp && left)) ? 2'b11 : (w_lp ? 2'b01 : 2'b10);
`else
    assign w_type = w_lp ? 2'b01 : 2'b10;
`endif

    assign w_sx     = div_step(r_rx, r_dx[POS_W-1], r_div);
    assign w_sy     = div_step(r_ry, r_dy[POS_W-1], r_div);
    assign w_qx_fin = {r_qx[POS_W-2:0], w_sx[POS_W]};
    assign w_qy_fin = {r_qy[POS_W-2:0], w_sy[POS_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        evt_valid  = 1'b0;
        busy       = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nx = S_CALC;
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == '0) w_state_nx = S_OUT;
            end
            S_OUT: begin
                busy      = 1'b1;
                evt_valid = 1'b1;
                if (evt_ready) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left_q  <= 1'b1;
            r_right_q <= 1'b1;
            r_dx      <= '0;
            r_dy      <= '0;
            r_rx      <= '0;
            r_ry      <= '0;
            r_qx      <= '0;
            r_qy      <= '0;
            r_div     <= '0;
            r_cap     <= '0;
            r_cnt     <= '0;
            r_type    <= 2'b00;
            r_evt_x   <= '0;
            r_evt_y   <= '0;
            r_miss    <= 1'b0;
        end else begin
            r_left_q  <= left;
            r_right_q <= right;
            r_miss    <= w_press && !w_accept;
            if (w_accept) begin
                r_dx   <= w_ox;
                r_dy   <= w_oy;
                r_rx   <= '0;
                r_ry   <= '0;
                r_qx   <= '0;
                r_qy   <= '0;
                r_div  <= button_size;
                r_cap  <= w_cap;
                r_cnt  <= CW'(POS_W-1);
                r_type <= w_type;
            end else if (r_state == S_CALC) begin
                r_dx <= r_dx << 1;
                r_dy <= r_dy << 1;
                r_rx <= w_sx[POS_W-1:0];
                r_ry <= w_sy[POS_W-1:0];
                r_qx <= w_qx_fin;
                r_qy <= w_qy_fin;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == '0) begin
                    r_evt_x <= sat_idx(w_qx_fin, r_cap);
                    r_evt_y <= sat_idx(w_qy_fin, r_cap);
                end
            end
        end
    end

    assign evt_x    = r_evt_x;
    assign evt_y    = r_evt_y;
    assign evt_type = r_type;
    assign miss     = r_miss;

endmodule
